// File: rtl/logic_op_scheduler.sv
// Two-requester round-robin scheduler for a shared AND/OR/XOR/NAND datapath.
// One operation in flight; the result is held under a valid/ready handshake.
module logic_op_scheduler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       dec,
  output logic             y_id,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  // state | meaning
  // IDLE  | arbitrate and latch the winner's operands
  // EXEC  | gnt pulse visible, compute result
  // HOLD  | result valid, wait for y_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             wid_q, wid_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       dec_q, dec_d;
  logic             y_id_q, y_id_d;
  logic             y_valid_q, y_valid_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [WIDTH-1:0] result;
  logic             win;

  always_comb begin
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~(a_q & b_q);
    endcase
  end

  // With both requesting, the rr pointer names the winner.
  assign win = (req0 && req1) ? rr_q : req1;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wid_d      = wid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    y_d        = y_q;
    dec_d      = dec_q;
    y_id_d     = y_id_q;
    y_valid_d  = y_valid_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en && (req0 || req1)) begin
          wid_d   = win;
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        y_d       = result;
        dec_d     = 4'b0001 << op_q;
        y_id_d    = wid_q;
        y_valid_d = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (y_ready) begin
          y_valid_d  = 1'b0;
          done_cnt_d = done_cnt_q + CNT_W'(1);
          rr_d       = ~y_id_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      wid_q      <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      y_q        <= '0;
      dec_q      <= 4'b0000;
      y_id_q     <= 1'b0;
      y_valid_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      wid_q      <= wid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      y_q        <= y_d;
      dec_q      <= dec_d;
      y_id_q     <= y_id_d;
      y_valid_q  <= y_valid_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign y        = y_q;
  assign dec      = dec_q;
  assign y_id     = y_id_q;
  assign y_valid  = y_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all cross-checked against a transaction-level model.
module tb_logic_op_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, en, req0, req1, y_ready;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, y_id, y_valid, busy;
  logic [3:0] y, dec;
  logic [7:0] done_cnt;

  int n_checks = 0;
  int n_err    = 0;

  logic_op_scheduler #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .y(y), .dec(dec), .y_id(y_id),
    .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gate(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Model: phase 0 = free to accept, 1 = operands taken (grant visible), 2 = result offered.
  int         m_phase = 0;
  bit         m_init  = 0;
  logic       m_rr, m_w, m_gnt0, m_gnt1, m_yid, m_valid;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b, m_y, m_dec;
  logic [7:0] m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_phase = 0; m_rr = 0; m_gnt0 = 0; m_gnt1 = 0;
      m_y = 0; m_dec = 0; m_yid = 0; m_valid = 0; m_cnt = 0;
    end else if (m_init) begin
      m_gnt0 = 0; m_gnt1 = 0;
      if (m_phase == 0) begin
        if (en && (req0 || req1)) begin
          if (req0 && req1) m_w = m_rr; else m_w = req1;
          m_op = m_w ? op1 : op0;
          m_a  = m_w ? a1 : a0;
          m_b  = m_w ? b1 : b0;
          if (m_w) m_gnt1 = 1; else m_gnt0 = 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_y = gate(m_op, m_a, m_b);
        m_dec = 4'(1 << m_op);
        m_yid = m_w;
        m_valid = 1;
        m_phase = 2;
      end else if (y_ready) begin
        m_valid = 0;
        m_cnt = m_cnt + 8'd1;
        m_rr = ~m_yid;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_gnt0", {31'd0, gnt0}, {31'd0, m_gnt0});
      chk("m_gnt1", {31'd0, gnt1}, {31'd0, m_gnt1});
      chk("m_y_valid", {31'd0, y_valid}, {31'd0, m_valid});
      chk("m_y", {28'd0, y}, {28'd0, m_y});
      chk("m_dec", {28'd0, dec}, {28'd0, m_dec});
      chk("m_y_id", {31'd0, y_id}, {31'd0, m_yid});
      chk("m_busy", {31'd0, busy}, {31'd0, m_phase != 0});
      chk("m_done_cnt", {24'd0, done_cnt}, {24'd0, m_cnt});
    end
  end

  // Ends on a negedge with the scheduler back in IDLE; y_ready must be 1.
  task automatic run_op(input bit id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ey, input logic [3:0] edec, input bit lit);
    bit got = 0;
    if (id) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((id ? gnt1 : gnt0) === 1'b1) got = 1;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    if (id) req1 = 0; else req0 = 0;
    @(negedge clk);
    if (lit) begin
      chk("op_valid", {31'd0, y_valid}, 1);
      chk("op_y", {28'd0, y}, {28'd0, ey});
      chk("op_dec", {28'd0, dec}, {28'd0, edec});
      chk("op_y_id", {31'd0, y_id}, {31'd0, id});
    end
    @(negedge clk);
    if (lit) chk("op_valid_drop", {31'd0, y_valid}, 0);
  endtask

  initial begin
    int order[$];
    logic [3:0] hy, hdec;
    logic [7:0] c0;

    rst_n = 0; en = 1; req0 = 1; req1 = 0; op0 = 2'b00; a0 = 4'b1110; b0 = 4'b0110;
    op1 = 0; a1 = 0; b1 = 0; y_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_y_valid", {31'd0, y_valid}, 0);
    chk("rst_y", {28'd0, y}, 0);
    chk("rst_dec", {28'd0, dec}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {24'd0, done_cnt}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("first_gnt0", {31'd0, gnt0}, 1);
    req0 = 0;
    @(negedge clk);
    chk("and_valid", {31'd0, y_valid}, 1);
    chk("and_y", {28'd0, y}, 4'b0110);
    chk("and_dec", {28'd0, dec}, 4'b0001);
    chk("and_y_id", {31'd0, y_id}, 0);
    @(negedge clk);
    chk("and_valid_drop", {31'd0, y_valid}, 0);
    chk("and_done", {24'd0, done_cnt}, 1);

    run_op(1, 2'b01, 4'b1110, 4'b0010, 4'b1110, 4'b0010, 1);
    run_op(1, 2'b10, 4'b1110, 4'b0010, 4'b1100, 4'b0100, 1);
    run_op(1, 2'b11, 4'b1110, 4'b0010, 4'b1101, 4'b1000, 1);
    chk("ops_done", {24'd0, done_cnt}, 4);

    // Contention: both held, each re-raises right after its grant.
    c0 = done_cnt;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      req0 = !gnt0; req1 = !gnt1;
    end
    req0 = 0; req1 = 0;
    chk("cont_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("cont_order", order[i], i % 2);
    repeat (3) @(negedge clk);
    chk("cont_done", {24'd0, done_cnt}, {24'd0, c0 + 8'd4});

    // Backpressure with a pending competing request.
    y_ready = 0;
    req0 = 1; op0 = 2'b10; a0 = 4'b1010; b0 = 4'b0110;
    for (int i = 0; i < 20 && gnt0 !== 1'b1; i++) @(negedge clk);
    req0 = 0; req1 = 1; op1 = 2'b00; a1 = 4'hF; b1 = 4'hF;
    @(negedge clk);
    hy = y; hdec = dec;
    chk("bp_y", {28'd0, hy}, 4'b1100);
    chk("bp_dec", {28'd0, hdec}, 4'b0100);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, y_valid}, 1);
      chk("bp_y_stable", {28'd0, y}, {28'd0, hy});
      chk("bp_dec_stable", {28'd0, dec}, {28'd0, hdec});
      chk("bp_busy", {31'd0, busy}, 1);
      chk("bp_no_gnt", {31'd0, gnt1}, 0);
    end
    y_ready = 1;
    @(negedge clk);
    chk("bp_idle", {31'd0, busy}, 0);
    req1 = 0;
    @(negedge clk);

    // Enable low blocks grants.
    en = 0; req0 = 1;
    repeat (5) begin
      @(negedge clk);
      chk("en_no_gnt", {31'd0, gnt0}, 0);
      chk("en_idle", {31'd0, busy}, 0);
    end
    req0 = 0; en = 1;

    // Reset during HOLD discards the result.
    rst_n = 0; @(negedge clk); rst_n = 1;
    y_ready = 0; req0 = 1; op0 = 2'b01; a0 = 4'h3; b0 = 4'h4;
    for (int i = 0; i < 20 && gnt0 !== 1'b1; i++) @(negedge clk);
    req0 = 0;
    repeat (2) @(negedge clk);
    chk("hold_valid", {31'd0, y_valid}, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("hold_rst_valid", {31'd0, y_valid}, 0);
    chk("hold_rst_done", {24'd0, done_cnt}, 0);
    y_ready = 1;

    // Counter wrap.
    for (int i = 0; i < 255; i++) run_op(i[0], 2'(i), 4'(i), 4'(i >> 2), 4'h0, 4'h0, 0);
    chk("wrap_255", {24'd0, done_cnt}, 255);
    run_op(0, 2'b11, 4'h5, 4'hA, 4'hF, 4'b1000, 1);
    chk("wrap_0", {24'd0, done_cnt}, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 9) != 0);
      y_ready = $urandom_range(0, 1);
      if (req0 && gnt0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
      end
      if (req1 && gnt1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/logic_op_scheduler.md
Name: logic_op_scheduler

Overview:
- Time-shares one 4-op logic-gate datapath (AND/OR/XOR/NAND on WIDTH-bit operands) between two requesters.
- Round-robin arbitration, latches the winner's operands and opcode, computes one registered result.
- Holds the result under a valid/ready handshake and counts completed operations.
- Sits between requesting blocks and the downstream consumer of gate results. Replaces direct select-line driving of the gate unit by multiple sources.

Parameters:
WIDTH, 4, operand/result width in bits
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  global enable; 0 blocks new grants (in-flight op completes)
req0  input  1  requester 0 request, level, held until gnt0
op0  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
req1  input  1  requester 1 request
op1  input  2  requester 1 opcode
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  one-cycle pulse: requester 0 operands accepted
gnt1  output  1  one-cycle pulse: requester 1 operands accepted
y  output  WIDTH  result
dec  output  4  one-hot decode of executed opcode (bit n set for opcode n)
y_id  output  1  requester that owns y
y_valid  output  1  result valid
y_ready  input  1  consumer accepts result
busy  output  1  high whenever state != IDLE
done_cnt  output  CNT_W  completed (handshaken) operations, wraps

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n. Reset is sampled only at a rising clk edge.
- Reset values: state=IDLE, gnt0=gnt1=0, y=0, dec=0, y_id=0, y_valid=0, busy=0, done_cnt=0, rr pointer=0 (requester 0 has priority first).
- States: IDLE, EXEC, HOLD.
- IDLE:
  - If en=1 and any req, pick the winner. A single request wins. If both request, the requester equal to the rr pointer wins.
  - Latch the winner's op/a/b, set the winner's gnt for exactly the next cycle, go to EXEC.
  - If en=0 or no req, stay in IDLE.
- EXEC (1 cycle):
  - Compute on latched operands: AND a&b, OR a|b, XOR a^b, NAND ~(a&b), full WIDTH.
  - Register y, dec=1<<op, y_id=winner; set y_valid=1; go to HOLD.
  - gnt is high during this cycle only.
- HOLD:
  - y, dec, y_id, y_valid are stable until y_valid&y_ready.
  - On handshake: y_valid=0 next cycle, done_cnt+1 (wraps 2^CNT_W-1 -> 0), rr pointer = ~y_id, go to IDLE.
  - y and dec keep their last values after the handshake.
- Latency: request seen in IDLE at edge N -> gnt high N+1 -> y_valid high N+2. Minimum issue interval is 3 cycles if y_ready is held at 1.
- Requests are ignored outside IDLE. Requesters must hold req and operands until their gnt.
- en is checked only in IDLE. Dropping en mid-operation does not abort EXEC/HOLD.
- y_ready while y_valid=0 has no effect.
- rst_n=0 in any state forces reset values on the next edge. The in-flight result is discarded and not counted.
- busy is combinational from state.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req0=1 -> all outputs 0, no gnt. Release -> gnt0 at the following cycle.
- Single op: en=1, req0=1, op0=00, a0=1110, b0=0110, y_ready=1 -> gnt0 1 cycle, then y=0110, dec=0001, y_id=0, y_valid 1 cycle, done_cnt=1.
- All opcodes, req1, a1=1110, b1=0010: 01 -> y=1110 dec=0010; 10 -> y=1100 dec=0100; 11 -> y=1101 dec=1000; y_id=1 each time.
- Contention: req0=req1=1 held -> grants alternate 0,1,0,1; each winner drops req after its gnt and re-raises it. done_cnt increments per handshake.
- Backpressure: y_ready=0 for 5 cycles -> y_valid, y, dec stable, busy=1, no new gnt despite pending req. y_ready=1 -> IDLE next cycle.
- Enable and reset mid-op: en=0 with req0=1 -> no gnt. Reset during HOLD -> y_valid=0 and done_cnt unchanged at 0. With CNT_W=8 and 256 operations, done_cnt wraps to 0.
